// File: rtl/aes_link_pkg.sv
// Shared types and constants for the AES chip link tester.
// The link is 9 bits wide: eight data bits plus a strobe on bit 8.
package aes_link_pkg;

    localparam int STROBE_BIT = 8;
    localparam int LINK_W     = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_RX,
        CHECK
    } link_state_t;

endpackage

// File: rtl/aes_link_sync.sv
// Brings the chip's 9-bit response bus into the clk domain through two flops.
// It also produces a one-cycle pulse on each rising edge of the synchronised strobe.
// The data byte it outputs is the synchronised copy that lines up with that pulse.
module aes_link_sync
    import aes_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINK_W-1:0] link_in,
    output logic [7:0]        link_data,
    output logic              strobe_rise
);

    logic [LINK_W-1:0] sync_1;
    logic [LINK_W-1:0] sync_2;
    logic              strobe_prev;

    // Two-stage synchroniser plus a delayed strobe copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1      <= '0;
            sync_2      <= '0;
            strobe_prev <= 1'b0;
        end else begin
            sync_1      <= link_in;
            sync_2      <= sync_1;
            strobe_prev <= sync_2[STROBE_BIT];
        end
    end

    assign link_data   = sync_2[7:0];
    assign strobe_rise = sync_2[STROBE_BIT] & ~strobe_prev;

endmodule

// File: rtl/aes_link_tester.sv
// Traffic and check engine for the byte-serial AES chip link.
// It serialises one stimulus frame per transaction and captures the response frame.
// It compares the response to the expected frame and counts total, correct and timed-out frames.
// Optional feature: define AES_LINK_TIMEOUT_EN to abort frames whose response stalls.
module aes_link_tester
    import aes_link_pkg::*;
#(
    parameter int TX_BYTES = 32,
    parameter int RX_BYTES = 16,
    parameter int TICK_DIV = 50,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  work,
    input  logic                  enc,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [TX_BYTES*8-1:0] src_data,
    input  logic [RX_BYTES*8-1:0] exp_data,
    output logic                  chip_enc,
    output logic [LINK_W-1:0]     aes_tx,
    input  logic [LINK_W-1:0]     aes_rx,
    output logic                  busy,
    output logic [CNT_W-1:0]      total,
    output logic [CNT_W-1:0]      correct,
    output logic [CNT_W-1:0]      timeouts
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TXC_W = $clog2(TX_BYTES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(TX_BYTES - 1);

    link_state_t           state;
    link_state_t           state_next;
    logic [TX_BYTES*8-1:0] tx_shift;
    logic [RX_BYTES*8-1:0] exp_shift;
    logic [RX_BYTES-1:0]   mismatch;
    logic [RX_BYTES-1:0]   rx_slot;
    logic [DIV_W-1:0]      div_cnt;
    logic [TXC_W-1:0]      tx_cnt;
    logic                  strobe_phase;
    logic [7:0]            rx_byte;
    logic                  rx_rise;
    logic                  tick;
    logic                  tx_done;
    logic                  capture;
    logic                  rx_done;
    logic                  timeout_hit;
    logic                  frame_timed_out;

    aes_link_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .link_in     (aes_rx),
        .link_data   (rx_byte),
        .strobe_rise (rx_rise)
    );

    assign tick    = (state == SEND) && (div_cnt == DIV_LAST);
    assign tx_done = tick && strobe_phase && (tx_cnt == TX_LAST);
    assign capture = (state == WAIT_RX) && rx_rise;
    assign rx_done = capture && rx_slot[RX_BYTES-1];

`ifdef AES_LINK_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  timeout_cnt;

    assign timeout_hit = (state == WAIT_RX) && !capture && (wait_cnt == WAIT_LAST);
    assign timeouts    = timeout_cnt;

    // Idle-cycle watchdog for the response, held at zero outside WAIT_RX and on every capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt        <= '0;
            timeout_cnt     <= '0;
            frame_timed_out <= 1'b0;
        end else begin
            if (state != WAIT_RX || capture) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (state == LOAD) begin
                frame_timed_out <= 1'b0;
            end else if (timeout_hit) begin
                frame_timed_out <= 1'b1;
                timeout_cnt     <= timeout_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign frame_timed_out = 1'b0;
    assign timeouts        = '0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_next = state;
        src_ready  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (work && src_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                src_ready  = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (tx_done) begin
                    state_next = WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (rx_done || timeout_hit) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = (work && src_valid) ? LOAD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame latch and transmit serialiser: strobe high for one tick, low for the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift     <= '0;
            chip_enc     <= 1'b0;
            aes_tx       <= '0;
            div_cnt      <= '0;
            tx_cnt       <= '0;
            strobe_phase <= 1'b0;
        end else begin
            if (state == SEND && !tick) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
            end
            if (state == LOAD) begin
                tx_shift     <= src_data;
                chip_enc     <= enc;
                aes_tx       <= '0;
                tx_cnt       <= '0;
                strobe_phase <= 1'b0;
            end else if (tick) begin
                if (!strobe_phase) begin
                    aes_tx       <= {1'b1, tx_shift[7:0]};
                    strobe_phase <= 1'b1;
                end else begin
                    aes_tx[STROBE_BIT] <= 1'b0;
                    strobe_phase       <= 1'b0;
                    tx_shift           <= tx_shift >> 8;
                    tx_cnt             <= tx_cnt + TXC_W'(1);
                end
            end
        end
    end

    // Response capture: each captured byte clears its mismatch bit when it equals the expected byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_shift <= '0;
            mismatch  <= '0;
            rx_slot   <= '0;
        end else if (state == LOAD) begin
            exp_shift <= exp_data;
            mismatch  <= '1;
            rx_slot   <= RX_BYTES'(1);
        end else if (capture) begin
            exp_shift <= exp_shift >> 8;
            rx_slot   <= rx_slot << 1;
            if (rx_byte == exp_shift[7:0]) begin
                mismatch <= mismatch & ~rx_slot;
            end
        end
    end

    // Frame result counters, wrapping and cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total   <= '0;
            correct <= '0;
        end else if (state == CHECK) begin
            total <= total + CNT_W'(1);
            if (mismatch == '0 && !frame_timed_out) begin
                correct <= correct + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_link_tester.sv
// Scoreboard bench for aes_link_tester with a small loopback chip model.
// The timeout scenario runs only when AES_LINK_TIMEOUT_EN is defined.
module tb_aes_link_tester;

    localparam int TX_BYTES = 2;
    localparam int RX_BYTES = 2;
    localparam int TICK_DIV = 4;
    localparam int TIMEOUT  = 64;
    localparam int CNT_W    = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  work;
    logic                  enc;
    logic                  src_valid;
    logic                  src_ready;
    logic [TX_BYTES*8-1:0] src_data;
    logic [RX_BYTES*8-1:0] exp_data;
    logic                  chip_enc;
    logic [8:0]            aes_tx;
    logic [8:0]            aes_rx;
    logic                  busy;
    logic [CNT_W-1:0]      total;
    logic [CNT_W-1:0]      correct;
    logic [CNT_W-1:0]      timeouts;

    aes_link_tester #(
        .TX_BYTES (TX_BYTES),
        .RX_BYTES (RX_BYTES),
        .TICK_DIV (TICK_DIV),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .work      (work),
        .enc       (enc),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .exp_data  (exp_data),
        .chip_enc  (chip_enc),
        .aes_tx    (aes_tx),
        .aes_rx    (aes_rx),
        .busy      (busy),
        .total     (total),
        .correct   (correct),
        .timeouts  (timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        logic       enc;
    } tx_exp_t;

    typedef struct {
        logic [15:0] reply;
        int          nreply;
    } reply_t;

    typedef struct {
        logic [CNT_W-1:0] total;
        logic [CNT_W-1:0] correct;
        logic [CNT_W-1:0] timeouts;
    } result_t;

    tx_exp_t tx_q[$];
    reply_t  reply_q[$];
    result_t result_q[$];

    int checks    = 0;
    int failures  = 0;
    int ready_cnt = 0;
    int cyc       = 0;

    logic [CNT_W-1:0] m_total    = '0;
    logic [CNT_W-1:0] m_correct  = '0;
    logic [CNT_W-1:0] m_timeouts = '0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pushes the expected tx bytes, reply and counter values, then offers the frame until accepted
    task automatic applyStimulus(input logic [15:0] src, input logic [15:0] expv, input logic [15:0] reply,
                                 input int nreply, input logic e, input logic keep_valid);
        int  n;
        logic got;
        tx_q.push_back(tx_exp_t'{src[7:0], TICK_DIV, e});
        tx_q.push_back(tx_exp_t'{src[15:8], 3 * TICK_DIV, e});
        reply_q.push_back(reply_t'{reply, nreply});
        m_total = m_total + 1;
        if (nreply == RX_BYTES && reply == expv) m_correct = m_correct + 1;
        if (nreply < RX_BYTES) m_timeouts = m_timeouts + 1;
        result_q.push_back(result_t'{m_total, m_correct, m_timeouts});
        src_data  = src;
        exp_data  = expv;
        enc       = e;
        src_valid = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 2000) begin
            @(negedge clk);
            n++;
            if (src_ready) got = 1'b1;
        end
        checkOutput("src_ready_wait", got, 1);
        @(posedge clk);
        #1;
        src_valid = keep_valid;
    endtask

    // Waits for every queued frame result to be seen and the FSM to return to IDLE
    task automatic waitDone(input int bound);
        int n;
        n = 0;
        while ((result_q.size() != 0 || busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_done_wait", n >= bound, 0);
        if (n >= bound) begin
            tx_q.delete();
            reply_q.delete();
            result_q.delete();
        end
    endtask

    // Monitor: cyc counts clock edges since the edge that consumed the frame
    initial begin : monitor
        logic             prev_strobe;
        logic [CNT_W-1:0] prev_total;
        tx_exp_t          te;
        result_t          re;
        prev_strobe = 1'b0;
        prev_total  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_strobe = 1'b0;
                prev_total  = '0;
                cyc         = 0;
            end else begin
                if (src_ready) begin
                    cyc = -1;
                    ready_cnt++;
                end else begin
                    cyc++;
                end
                if (aes_tx[8] && !prev_strobe) begin
                    checkOutput("tx_expected", tx_q.size() != 0, 1);
                    if (tx_q.size() != 0) begin
                        te = tx_q.pop_front();
                        checkOutput("tx_data", aes_tx[7:0], te.data);
                        checkOutput("tx_cycle", cyc, te.cyc);
                        checkOutput("chip_enc", chip_enc, te.enc);
                    end
                end
                if (total != prev_total) begin
                    checkOutput("result_expected", result_q.size() != 0, 1);
                    if (result_q.size() != 0) begin
                        re = result_q.pop_front();
                        checkOutput("total", total, re.total);
                        checkOutput("correct", correct, re.correct);
                        checkOutput("timeouts", timeouts, re.timeouts);
                    end
                end
                prev_strobe = aes_tx[8];
                prev_total  = total;
            end
        end
    end

    // Loopback chip model: after the last stimulus strobe, replies with 4-high/4-low strobes
    initial begin : chip_model
        logic   rm_prev;
        logic   rm_active;
        logic   s;
        int     rm_seen;
        int     rm_step;
        int     b;
        reply_t cur;
        aes_rx    = '0;
        rm_prev   = 1'b0;
        rm_active = 1'b0;
        rm_seen   = 0;
        rm_step   = 0;
        cur       = reply_t'{16'h0, 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aes_rx    = '0;
                rm_prev   = 1'b0;
                rm_active = 1'b0;
                rm_seen   = 0;
            end else begin
                if (aes_tx[8] && !rm_prev) rm_seen++;
                rm_prev = aes_tx[8];
                if (!rm_active && rm_seen == TX_BYTES) begin
                    rm_seen = 0;
                    if (reply_q.size() != 0) begin
                        cur       = reply_q.pop_front();
                        rm_active = 1'b1;
                        rm_step   = -8;
                    end
                end else if (rm_active) begin
                    if (rm_step >= 0) begin
                        if (rm_step >= 8 * cur.nreply) begin
                            rm_active = 1'b0;
                            aes_rx    = '0;
                        end else begin
                            b      = rm_step / 8;
                            s      = (rm_step % 8) < 4;
                            aes_rx = {s, cur.reply[b*8 +: 8]};
                        end
                    end
                    rm_step++;
                end
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        int r0;
        rst_n     = 1'b0;
        work      = 1'b0;
        enc       = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        exp_data  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_aes_tx", aes_tx, 0);
        checkOutput("rst_chip_enc", chip_enc, 0);
        checkOutput("rst_src_ready", src_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_total", total, 0);
        checkOutput("rst_correct", correct, 0);
        checkOutput("rst_timeouts", timeouts, 0);
        #1 rst_n = 1'b1;
        work = 1'b1;

        $display("[TB] matching loopback frame");
        applyStimulus(16'h5AA5, 16'h1234, 16'h1234, 2, 1'b1, 1'b0);
        waitDone(400);

        $display("[TB] reply differs in one bit");
        applyStimulus(16'h5AA5, 16'h1234, 16'h1235, 2, 1'b0, 1'b0);
        waitDone(400);

        $display("[TB] reset during SEND");
        applyStimulus(16'hC33C, 16'h0F0F, 16'h0F0F, 2, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        tx_q.delete();
        reply_q.delete();
        result_q.delete();
        m_total    = '0;
        m_correct  = '0;
        m_timeouts = '0;
        @(negedge clk);
        checkOutput("midrst_aes_tx", aes_tx, 0);
        checkOutput("midrst_chip_enc", chip_enc, 0);
        checkOutput("midrst_src_ready", src_ready, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_total", total, 0);
        checkOutput("midrst_correct", correct, 0);
        #1 rst_n = 1'b1;
        applyStimulus(16'hC33C, 16'h0F0F, 16'h0F0F, 2, 1'b1, 1'b0);
        waitDone(400);

        $display("[TB] three back-to-back frames");
        r0 = ready_cnt;
        applyStimulus(16'h1111, 16'hAAAA, 16'hAAAA, 2, 1'b1, 1'b1);
        applyStimulus(16'h2222, 16'hBBBB, 16'hBBBB, 2, 1'b0, 1'b1);
        applyStimulus(16'h3333, 16'hCCCC, 16'hCCCC, 2, 1'b1, 1'b0);
        waitDone(600);
        checkOutput("ready_pulses", ready_cnt - r0, 3);

        $display("[TB] work dropped during SEND");
        r0 = ready_cnt;
        applyStimulus(16'h7E81, 16'h4242, 16'h4242, 2, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        work = 1'b0;
        waitDone(400);
        checkOutput("busy_after_drop", busy, 0);
        repeat (40) @(negedge clk);
        checkOutput("ready_after_drop", ready_cnt - r0, 1);
        checkOutput("busy_idle_off", busy, 0);
        src_valid = 1'b0;
        work      = 1'b1;

`ifdef AES_LINK_TIMEOUT_EN
        $display("[TB] response stalls after one byte");
        applyStimulus(16'h0102, 16'h5566, 16'h5566, 1, 1'b0, 1'b0);
        waitDone(600);
        checkOutput("busy_after_timeout", busy, 0);
        checkOutput("timeouts_final", timeouts, 1);
`endif

        repeat (10) @(negedge clk);
        checkOutput("tx_queue_empty", tx_q.size(), 0);
        checkOutput("total_final", total, m_total);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_link_tester.md
# aes_link_tester

Parametrised traffic and check engine for the byte-serial AES chip link. It serialises a stimulus frame onto the 9-bit chip bus (8 data bits + strobe) at a programmable tick rate and captures the chip's response frame. It compares the response against an expected frame and keeps total, correct and timeout counters. It sits in the verification platform between the frame source (pattern/golden generator) and the AES chip pins, and replaces the fixed-size, fixed-rate transmit/compare logic.

## Interface
- `TX_BYTES`, 32: stimulus bytes per frame (key + block).
- `RX_BYTES`, 16: response bytes per frame.
- `TICK_DIV`, 50: clk cycles per link tick (≥2).
- `TIMEOUT`, 4096: max clk cycles between response bytes.
- `CNT_W`, 32: counter width.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `work` in 1: run enable (level).
- `enc` in 1: mode request, 1 = encrypt.
- `src_valid` in 1: stimulus/expected frame available.
- `src_ready` out 1: frame accepted this cycle.
- `src_data` in TX_BYTES*8: stimulus, byte 0 = bits [7:0], sent first.
- `exp_data` in RX_BYTES*8: expected response, byte 0 = bits [7:0].
- `chip_enc` out 1: mode to chip, stable for a whole frame.
- `aes_tx` out 9: [7:0] data, [8] strobe.
- `aes_rx` in 9: [7:0] data, [8] strobe, chip clock domain.
- `busy` out 1: FSM not IDLE.
- `total` out CNT_W: frames completed, including timed-out frames.
- `correct` out CNT_W: frames with all bytes matching.
- `timeouts` out CNT_W: frames aborted by timeout.

## Operation
- FSM states:
  - IDLE → LOAD when `work`=1 and `src_valid`=1.
  - LOAD: 1 cycle. `src_ready`=1, latch `src_data`, `exp_data` and `enc` into `chip_enc`. → SEND.
  - SEND: one byte per tick, byte index 0..TX_BYTES-1. At each tick, drive `aes_tx[7:0]`=byte and `aes_tx[8]`=1 for exactly one tick; `aes_tx[8]`=0 for the following tick (strobe duty 50%). After the last byte's low tick → WAIT_RX.
  - WAIT_RX: on each synchronised rising edge of `aes_rx[8]`, store `aes_rx[7:0]` as the next response byte and clear the mismatch accumulator bit for that byte if equal. After RX_BYTES bytes → CHECK.
  - CHECK: 1 cycle. `total`+1; `correct`+1 if no mismatch. → LOAD if `work`=1 and `src_valid`=1, else IDLE.
- `work` falling mid-frame: the current frame completes and is counted. No new frame is loaded.
- `aes_rx` strobes in IDLE/LOAD/SEND are ignored and not counted.
- Counters wrap modulo 2^CNT_W. They are never cleared except by reset.
- Strobes arriving in WAIT_RX are never dropped. The gap between rx strobes is ≥3 clk.

## Timing
- Reset: `aes_tx`=0, `chip_enc`=0, `src_ready`=0, `busy`=0, all counters 0, FSM IDLE, tick divider 0.
- The tick divider runs only in SEND and restarts at 0 on entry, so the first strobe rises TICK_DIV clk after LOAD.
- SEND duration: 2·TX_BYTES·TICK_DIV cycles.
- `aes_rx` passes through a 2-flop synchroniser plus edge detect. Capture happens 3 clk after the pin edge. `aes_rx[7:0]` is sampled from the synchronised copy aligned with the strobe.
- Counters update on the CHECK clock edge and are visible the next cycle.
- Frame-to-frame: CHECK → LOAD takes 1 cycle when the source is valid.

## Configuration
- `AES_LINK_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_RX and resets on every captured byte and on state entry.
  - When it reaches TIMEOUT, go to CHECK with the frame forced incorrect, and `timeouts`+1.
- Not defined: WAIT_RX waits indefinitely; `timeouts` is tied to 0.

## Structure
- Package `aes_link_pkg`: FSM state typedef (IDLE, LOAD, SEND, WAIT_RX, CHECK), `STROBE_BIT`=8, `LINK_W`=9.
- Sub-module `aes_link_sync`: 2-flop synchroniser for the 9-bit bus plus rising-edge pulse on bit 8. Its reset is asynchronous active-low on `rst_n`.

## Test plan
Bench parameters: TX_BYTES=2, RX_BYTES=2, TICK_DIV=4, TIMEOUT=64.
- Reset mid-SEND → next cycle all outputs at reset values; FSM IDLE; re-run starts from byte 0.
- src 0x5AA5, loopback model replies 0x1234, exp 0x1234 → strobes at clk 4 and 12 after LOAD with data 0xA5 then 0x5A; total=1, correct=1.
- Same frame but reply 0x1235 → total=1, correct=0.
- `work` held 1, three valid frames → total=3; `src_ready` pulses 3 times; `chip_enc` follows `enc` latched per frame.
- With `AES_LINK_TIMEOUT_EN`, model replies 1 of 2 bytes → after 64 idle clk: total=1, correct=0, timeouts=1; FSM returns to IDLE.
- `work` dropped during SEND → frame completes and counts; `busy`=0 after CHECK; no further `src_ready`.
